// File: rtl/sd_block_cache_if.sv
// Bus bundle for sd_block_cache: CPU word port, flush handshake and the
// sd_controller block port. "slave" is the cache side, "master" the environment.
interface sd_block_cache_if;
  logic          CYC_I;
  logic          STB_I;
  logic          WE_I;
  logic [3:0]    SEL_I;
  logic [31:0]   ADR_I;
  logic [31:0]   DAT_I;
  logic [31:0]   DAT_O;
  logic          ACK_O;
  logic          FLUSH_I;
  logic          FLUSH_DONE_O;
  logic          SD_CYC_O;
  logic          SD_STB_O;
  logic          SD_WE_O;
  logic [31:0]   SD_ADR_O;
  logic [4095:0] SD_DAT_O;
  logic [4095:0] SD_DAT_I;
  logic          SD_ACK_I;

  modport slave (
    input  CYC_I, STB_I, WE_I, SEL_I, ADR_I, DAT_I, FLUSH_I, SD_DAT_I, SD_ACK_I,
    output DAT_O, ACK_O, FLUSH_DONE_O, SD_CYC_O, SD_STB_O, SD_WE_O, SD_ADR_O, SD_DAT_O
  );

  modport master (
    output CYC_I, STB_I, WE_I, SEL_I, ADR_I, DAT_I, FLUSH_I, SD_DAT_I, SD_ACK_I,
    input  DAT_O, ACK_O, FLUSH_DONE_O, SD_CYC_O, SD_STB_O, SD_WE_O, SD_ADR_O, SD_DAT_O
  );
endinterface

// File: rtl/sd_block_cache.sv
// Single-line write-back cache of one 512-byte SD block in front of a 32-bit CPU bus.
// Misses write back a dirty line, then refill; FLUSH_I writes back without evicting.
module sd_block_cache #(
  parameter bit SDSC = 1'b0
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  sd_block_cache_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WB        = 3'd1;
  localparam logic [2:0] S_WB_DONE   = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_FILL_DONE = 3'd4;
  localparam int         NUM_LANES   = 4;

  logic [2:0]    r_state;
  logic          r_valid;
  logic          r_dirty;
  logic          r_flush;
  logic [22:0]   r_tag;
  logic [22:0]   r_fill_tag;
  logic [4095:0] r_line;
  logic          r_ack;
  logic [31:0]   r_dat_o;
  logic          r_flush_done;
  logic          r_sd_cyc;
  logic          r_sd_we;
  logic [31:0]   r_sd_adr;

  logic          w_req;
  logic          w_hit;
  logic [22:0]   w_tag;
  logic [6:0]    w_idx;
  logic [11:0]   w_base;
  logic [31:0]   w_word;
  logic [31:0]   w_merged;
  logic          w_unused;

  assign w_tag    = bus.ADR_I[31:9];
  assign w_idx    = bus.ADR_I[8:2];
  assign w_base   = {w_idx, 5'b0};
  assign w_req    = bus.CYC_I & bus.STB_I & ~r_ack;
  assign w_hit    = r_valid & (r_tag == w_tag);
  assign w_word   = r_line[w_base +: 32];
  assign w_unused = ^bus.ADR_I[1:0];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign w_merged[8*k +: 8] = bus.SEL_I[k] ? bus.DAT_I[8*k +: 8] : w_word[8*k +: 8];
  end

  function automatic logic [31:0] f_sd_adr(input logic [22:0] tag);
    return SDSC ? {tag, 9'b0} : {9'b0, tag};
  endfunction

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_dirty      <= 1'b0;
      r_flush      <= 1'b0;
      r_tag        <= '0;
      r_fill_tag   <= '0;
      r_line       <= '0;
      r_ack        <= 1'b0;
      r_dat_o      <= '0;
      r_flush_done <= 1'b0;
      r_sd_cyc     <= 1'b0;
      r_sd_we      <= 1'b0;
      r_sd_adr     <= '0;
    end else begin
      r_ack        <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.FLUSH_I) begin
            if (r_dirty) begin
              r_flush  <= 1'b1;
              r_state  <= S_WB;
              r_sd_cyc <= 1'b1;
              r_sd_we  <= 1'b1;
              r_sd_adr <= f_sd_adr(r_tag);
            end else begin
              r_flush_done <= 1'b1;
            end
          end else if (w_req) begin
            if (w_hit) begin
              r_ack <= 1'b1;
              if (bus.WE_I) begin
                r_line[w_base +: 32] <= w_merged;
                r_dirty              <= r_dirty | (|bus.SEL_I);
                r_dat_o              <= w_merged;
              end else begin
                r_dat_o <= w_word;
              end
            end else if (r_dirty) begin
              r_state  <= S_WB;
              r_sd_cyc <= 1'b1;
              r_sd_we  <= 1'b1;
              r_sd_adr <= f_sd_adr(r_tag);
            end else begin
              r_state    <= S_FILL;
              r_sd_cyc   <= 1'b1;
              r_sd_we    <= 1'b0;
              r_sd_adr   <= f_sd_adr(w_tag);
              r_fill_tag <= w_tag;
            end
          end
        end
        S_WB: begin
          if (bus.SD_ACK_I) begin
            r_sd_cyc <= 1'b0;
            r_sd_we  <= 1'b0;
            r_state  <= S_WB_DONE;
          end
        end
        // Strobes are low for this whole cycle, separating WB from FILL.
        S_WB_DONE: begin
          r_dirty <= 1'b0;
          if (r_flush) begin
            r_flush      <= 1'b0;
            r_flush_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_state    <= S_FILL;
            r_sd_cyc   <= 1'b1;
            r_sd_we    <= 1'b0;
            r_sd_adr   <= f_sd_adr(w_tag);
            r_fill_tag <= w_tag;
          end
        end
        // The tag is latched at FILL entry so it always matches the block fetched.
        S_FILL: begin
          if (bus.SD_ACK_I) begin
            r_line   <= bus.SD_DAT_I;
            r_tag    <= r_fill_tag;
            r_valid  <= 1'b1;
            r_dirty  <= 1'b0;
            r_sd_cyc <= 1'b0;
            r_state  <= S_FILL_DONE;
          end
        end
        S_FILL_DONE: r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.DAT_O        = r_dat_o;
  assign bus.ACK_O        = r_ack;
  assign bus.FLUSH_DONE_O = r_flush_done;
  assign bus.SD_CYC_O     = r_sd_cyc;
  assign bus.SD_STB_O     = r_sd_cyc;
  assign bus.SD_WE_O      = r_sd_we;
  assign bus.SD_ADR_O     = r_sd_adr;
  assign bus.SD_DAT_O     = r_line;

endmodule

// File: tb/tb_sd_block_cache.sv
// Scoreboard bench for sd_block_cache: two instances (block-number and byte addressing),
// SD card models, and per-instance monitors popping expected events in order.
module tb_sd_block_cache;

  localparam int EV_ACK = 0, EV_FDONE = 1, EV_SDWR = 2, EV_SDRD = 3;

  typedef struct {
    int          kind;
    logic        chk;
    logic [31:0] dat;
    logic [31:0] adr;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, inject0;
  ev_t  q0[$], q1[$];
  int   n_cmp = 0, n_bad = 0;

  sd_block_cache_if b0();
  sd_block_cache_if b1();

  sd_block_cache #(.SDSC(1'b0)) dut0 (.CLK_I(clk), .RST_I(rst0), .bus(b0));
  sd_block_cache #(.SDSC(1'b1)) dut1 (.CLK_I(clk), .RST_I(rst1), .bus(b1));

  function automatic ev_t mk(input int k, input logic c, input logic [31:0] d, input logic [31:0] a);
    ev_t e;
    e.kind = k; e.chk = c; e.dat = d; e.adr = a;
    return e;
  endfunction

  function automatic logic [4095:0] blk(input logic [31:0] n);
    logic [4095:0] d;
    for (int i = 0; i < 128; i++) d[i*32 +: 32] = (n == 1) ? 32'(i) : {n[15:0], 16'(i)};
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ev(input string who, input ev_t e, input int k, input logic [31:0] d, input logic [31:0] a);
    chk({who, " event kind"}, 32'(k), 32'(e.kind));
    if (e.chk) chk({who, " data"}, d, e.dat);
    if (k >= EV_SDWR) chk({who, " sd address"}, a, e.adr);
  endtask

  task automatic take0(input int k, input logic [31:0] d, input logic [31:0] a);
    ev_t e;
    if (q0.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL dut0 unexpected event: got kind %0d data 0x%08h expected none", k, d);
    end else begin
      e = q0.pop_front();
      check_ev("dut0", e, k, d, a);
    end
  endtask

  task automatic take1(input int k, input logic [31:0] d, input logic [31:0] a);
    ev_t e;
    if (q1.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL dut1 unexpected event: got kind %0d data 0x%08h expected none", k, d);
    end else begin
      e = q1.pop_front();
      check_ev("dut1", e, k, d, a);
    end
  endtask

  // SD card models: acknowledge two cycles after the strobe rises
  initial begin : sd_model0
    int cnt;
    cnt = 0; b0.SD_ACK_I = 1'b0; b0.SD_DAT_I = '0;
    forever begin
      @(negedge clk);
      if (b0.SD_ACK_I) begin
        b0.SD_ACK_I = 1'b0; cnt = 0;
      end else if (inject0) begin
        b0.SD_ACK_I = 1'b1; b0.SD_DAT_I = {4096{1'b1}};
      end else if (b0.SD_STB_O) begin
        cnt++;
        if (cnt >= 2) begin
          b0.SD_ACK_I = 1'b1;
          b0.SD_DAT_I = b0.SD_WE_O ? '0 : blk(b0.SD_ADR_O);
        end
      end else cnt = 0;
    end
  end

  initial begin : sd_model1
    int cnt;
    cnt = 0; b1.SD_ACK_I = 1'b0; b1.SD_DAT_I = '0;
    forever begin
      @(negedge clk);
      if (b1.SD_ACK_I) begin
        b1.SD_ACK_I = 1'b0; cnt = 0;
      end else if (b1.SD_STB_O) begin
        cnt++;
        if (cnt >= 2) begin
          b1.SD_ACK_I = 1'b1;
          b1.SD_DAT_I = b1.SD_WE_O ? '0 : blk(b1.SD_ADR_O >> 9);
        end
      end else cnt = 0;
    end
  end

  initial begin : mon0
    logic pstb;
    pstb = 1'b0;
    forever begin
      @(negedge clk);
      if (b0.ACK_O) take0(EV_ACK, b0.DAT_O, 32'h0);
      if (b0.FLUSH_DONE_O) take0(EV_FDONE, 32'h0, 32'h0);
      if (b0.SD_STB_O && !pstb) take0(b0.SD_WE_O ? EV_SDWR : EV_SDRD, b0.SD_DAT_O[95:64], b0.SD_ADR_O);
      pstb = b0.SD_STB_O;
    end
  end

  initial begin : mon1
    logic pstb;
    pstb = 1'b0;
    forever begin
      @(negedge clk);
      if (b1.ACK_O) take1(EV_ACK, b1.DAT_O, 32'h0);
      if (b1.FLUSH_DONE_O) take1(EV_FDONE, 32'h0, 32'h0);
      if (b1.SD_STB_O && !pstb) take1(b1.SD_WE_O ? EV_SDWR : EV_SDRD, b1.SD_DAT_O[95:64], b1.SD_ADR_O);
      pstb = b1.SD_STB_O;
    end
  end

  task automatic cpu0(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    b0.CYC_I = 1'b1; b0.STB_I = 1'b1; b0.WE_I = we; b0.SEL_I = sel; b0.ADR_I = adr; b0.DAT_I = dat;
    do begin @(negedge clk); n++; end while (!b0.ACK_O && n < 200);
    b0.CYC_I = 1'b0; b0.STB_I = 1'b0; b0.WE_I = 1'b0;
    if (!b0.ACK_O) begin
      n_cmp++; n_bad++;
      $display("FAIL dut0 ack timeout: got no ACK_O at 0x%08h expected ACK_O within 200 cycles", adr);
    end else if (lat > 0) chk("dut0 hit ack latency", 32'(n), 32'(lat));
  endtask

  task automatic cpu1(input logic [31:0] adr);
    int n;
    n = 0;
    @(negedge clk);
    b1.CYC_I = 1'b1; b1.STB_I = 1'b1; b1.WE_I = 1'b0; b1.SEL_I = 4'hf; b1.ADR_I = adr;
    do begin @(negedge clk); n++; end while (!b1.ACK_O && n < 200);
    b1.CYC_I = 1'b0; b1.STB_I = 1'b0;
    if (!b1.ACK_O) begin
      n_cmp++; n_bad++;
      $display("FAIL dut1 ack timeout: got no ACK_O at 0x%08h expected ACK_O within 200 cycles", adr);
    end
  endtask

  task automatic flush0(input int lat);
    int n;
    n = 0;
    @(negedge clk);
    b0.FLUSH_I = 1'b1;
    do begin @(negedge clk); n++; b0.FLUSH_I = 1'b0; end while (!b0.FLUSH_DONE_O && n < 200);
    if (!b0.FLUSH_DONE_O) begin
      n_cmp++; n_bad++;
      $display("FAIL dut0 flush timeout: got no FLUSH_DONE_O expected pulse within 200 cycles");
    end else if (lat > 0) chk("dut0 clean flush latency", 32'(n), 32'(lat));
  endtask

  task automatic reset_checks(input string who, input logic ack, input logic [31:0] dat, input logic fd,
                              input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                              input logic [31:0] w2);
    chk({who, " reset ACK_O"}, 32'(ack), 32'h0);
    chk({who, " reset DAT_O"}, dat, 32'h0);
    chk({who, " reset FLUSH_DONE_O"}, 32'(fd), 32'h0);
    chk({who, " reset SD_CYC_O"}, 32'(cyc), 32'h0);
    chk({who, " reset SD_STB_O"}, 32'(stb), 32'h0);
    chk({who, " reset SD_WE_O"}, 32'(we), 32'h0);
    chk({who, " reset SD_ADR_O"}, adr, 32'h0);
    chk({who, " reset line word 2"}, w2, 32'h0);
  endtask

  initial begin : stim
    int n;
    rst0 = 1'b0; rst1 = 1'b0; inject0 = 1'b0;
    b0.CYC_I = 0; b0.STB_I = 0; b0.WE_I = 0; b0.SEL_I = 0; b0.ADR_I = 0; b0.DAT_I = 0; b0.FLUSH_I = 0;
    b1.CYC_I = 0; b1.STB_I = 0; b1.WE_I = 0; b1.SEL_I = 0; b1.ADR_I = 0; b1.DAT_I = 0; b1.FLUSH_I = 0;
    repeat (3) @(negedge clk);
    reset_checks("dut0", b0.ACK_O, b0.DAT_O, b0.FLUSH_DONE_O, b0.SD_CYC_O, b0.SD_STB_O,
                 b0.SD_WE_O, b0.SD_ADR_O, b0.SD_DAT_O[95:64]);
    reset_checks("dut1", b1.ACK_O, b1.DAT_O, b1.FLUSH_DONE_O, b1.SD_CYC_O, b1.SD_STB_O,
                 b1.SD_WE_O, b1.SD_ADR_O, b1.SD_DAT_O[95:64]);
    rst0 = 1'b1; rst1 = 1'b1;

    // cold miss fills block 1
    q0.push_back(mk(EV_SDRD, 1'b0, 32'h0, 32'h1));
    q0.push_back(mk(EV_ACK, 1'b1, 32'h0000_0001, 32'h0));
    cpu0(1'b0, 4'hf, 32'h0000_0204, 32'h0, 0);

    // partial write hit, read back
    q0.push_back(mk(EV_ACK, 1'b0, 32'h0, 32'h0));
    cpu0(1'b1, 4'b0011, 32'h0000_0208, 32'hDEAD_BEEF, 1);
    q0.push_back(mk(EV_ACK, 1'b1, 32'h0000_BEEF, 32'h0));
    cpu0(1'b0, 4'hf, 32'h0000_0208, 32'h0, 1);

    // dirty miss: write back block 1, fill block 2
    q0.push_back(mk(EV_SDWR, 1'b1, 32'h0000_BEEF, 32'h1));
    q0.push_back(mk(EV_SDRD, 1'b0, 32'h0, 32'h2));
    q0.push_back(mk(EV_ACK, 1'b1, 32'h0002_0000, 32'h0));
    cpu0(1'b0, 4'hf, 32'h0000_0400, 32'h0, 0);

    // dirty flush keeps the line, clean flush is immediate; SEL_I=0 write stays clean
    q0.push_back(mk(EV_ACK, 1'b0, 32'h0, 32'h0));
    cpu0(1'b1, 4'hf, 32'h0000_0404, 32'h1122_3344, 1);
    q0.push_back(mk(EV_SDWR, 1'b1, 32'h0002_0002, 32'h2));
    q0.push_back(mk(EV_FDONE, 1'b0, 32'h0, 32'h0));
    flush0(0);
    q0.push_back(mk(EV_ACK, 1'b1, 32'h1122_3344, 32'h0));
    cpu0(1'b0, 4'hf, 32'h0000_0404, 32'h0, 1);
    q0.push_back(mk(EV_ACK, 1'b0, 32'h0, 32'h0));
    cpu0(1'b1, 4'b0000, 32'h0000_0404, 32'hFFFF_FFFF, 1);
    q0.push_back(mk(EV_FDONE, 1'b0, 32'h0, 32'h0));
    flush0(1);

    // flush and miss together: flush first, then fill block 3
    q0.push_back(mk(EV_ACK, 1'b0, 32'h0, 32'h0));
    cpu0(1'b1, 4'b1100, 32'h0000_0408, 32'hCAFE_F00D, 1);
    q0.push_back(mk(EV_SDWR, 1'b1, 32'hCAFE_0002, 32'h2));
    q0.push_back(mk(EV_FDONE, 1'b0, 32'h0, 32'h0));
    q0.push_back(mk(EV_SDRD, 1'b0, 32'h0, 32'h3));
    q0.push_back(mk(EV_ACK, 1'b1, 32'h0003_0000, 32'h0));
    fork
      flush0(0);
      cpu0(1'b0, 4'hf, 32'h0000_0600, 32'h0, 0);
    join

    // stray SD ack in IDLE must not touch the line
    @(posedge clk); inject0 = 1'b1;
    @(posedge clk); inject0 = 1'b0;
    repeat (2) @(negedge clk);
    q0.push_back(mk(EV_ACK, 1'b1, 32'h0003_0000, 32'h0));
    cpu0(1'b0, 4'hf, 32'h0000_0600, 32'h0, 1);

    // byte-addressed instance; reset during a fill invalidates the line
    q1.push_back(mk(EV_SDRD, 1'b0, 32'h0, 32'h0000_0600));
    q1.push_back(mk(EV_ACK, 1'b1, 32'h0003_0000, 32'h0));
    cpu1(32'h0000_0600);
    q1.push_back(mk(EV_SDRD, 1'b0, 32'h0, 32'h0000_0800));
    @(negedge clk);
    b1.CYC_I = 1'b1; b1.STB_I = 1'b1; b1.WE_I = 1'b0; b1.ADR_I = 32'h0000_0800;
    n = 0;
    do begin @(negedge clk); n++; end while (!b1.SD_STB_O && n < 200);
    chk("dut1 fill strobe seen", 32'(b1.SD_STB_O), 32'h1);
    rst1 = 1'b0; b1.CYC_I = 1'b0; b1.STB_I = 1'b0;
    @(negedge clk);
    chk("dut1 SD_STB_O after reset", 32'(b1.SD_STB_O), 32'h0);
    chk("dut1 ACK_O after reset", 32'(b1.ACK_O), 32'h0);
    rst1 = 1'b1;
    q1.push_back(mk(EV_SDRD, 1'b0, 32'h0, 32'h0000_0600));
    q1.push_back(mk(EV_ACK, 1'b1, 32'h0003_0000, 32'h0));
    cpu1(32'h0000_0600);

    repeat (5) @(negedge clk);
    chk("dut0 expected events left", 32'(q0.size()), 32'h0);
    chk("dut1 expected events left", 32'(q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
